// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Mode codes, FSM state encodings and the shift-mode predicate.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        r = 1'b0;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR,
            MODE_ROL, MODE_ASR: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_shift_next.sv
// Next-state datapath for the shift register.
// Pure combinational; shared by single-step and burst paths.
module usr_shift_next
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        unique case (mode)
            MODE_HOLD: next_q = q;
            MODE_SHR:  next_q = {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  next_q = {q[WIDTH-2:0], sin_l};
            MODE_LOAD: next_q = pdata;
            MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  next_q = '0;
        endcase
    end

endmodule

// File: rtl/univ_shiftreg.sv
// Universal shift register with single-step ops and a burst engine.
// The burst latches mode/count at start and runs unattended.
module univ_shiftreg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = 4'b1010,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [2:0]       bmode;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] next_q;

    // During a burst the latched mode drives the datapath.
    assign op_mode = (state == ST_BURST) ? bmode : mode;

    usr_shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q),
        .mode   (op_mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pdata  (pdata),
        .next_q (next_q)
    );

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= RESET_VAL;
            state     <= ST_IDLE;
            bmode     <= MODE_HOLD;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (count != '0 && is_shift_mode(mode)) begin
                            bmode     <= mode;
                            remaining <= count;
                            busy      <= 1'b1;
                            state     <= ST_BURST;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (en) begin
                        q <= next_q;
                    end
                end
                ST_BURST: begin
                    q         <= next_q;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shiftreg.sv
// Directed bench for univ_shiftreg with a queued expectation scoreboard.
// Expectations are queued before each edge and drained just after it.
module tb_univ_shiftreg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    localparam int K_Q    = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;
    localparam int K_SR   = 3;
    localparam int K_SL   = 4;

    typedef struct {
        string      tag;
        int         kind;
        logic [3:0] val;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    int   n_checks;
    int   n_fails;
    exp_t sb[$];

    univ_shiftreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (4'b1010)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pdata  (pdata),
        .start  (start),
        .count  (count),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_v(input string tag, input int kind,
                            input logic [3:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_st(input string tag, input logic [3:0] qv,
                             input logic b, input logic d);
        expect_v({tag, ".q"}, K_Q, qv);
        expect_v({tag, ".busy"}, K_BUSY, {3'b0, b});
        expect_v({tag, ".done"}, K_DONE, {3'b0, d});
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_Q:     obs = q;
                K_BUSY:  obs = {3'b0, busy};
                K_DONE:  obs = {3'b0, done};
                K_SR:    obs = {3'b0, sout_r};
                default: obs = {3'b0, sout_l};
            endcase
            n_checks++;
            assert (obs === e.val)
            else begin
                n_fails++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        en    = 1'b0;
        mode  = 3'b000;
        sin_r = 1'b0;
        sin_l = 1'b0;
        pdata = '0;
        start = 1'b0;
        count = '0;

        #1;
        expect_st("rst", 4'b1010, 1'b0, 1'b0);
        expect_v("rst.sout_r", K_SR, 4'd0);
        expect_v("rst.sout_l", K_SL, 4'd1);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single-step SHR
        en = 1'b1; mode = 3'b001; sin_r = 1'b1;
        expect_v("shr1.q", K_Q, 4'b1101);
        expect_v("shr1.sout_r", K_SR, 4'd1);
        tick();
        expect_v("shr2.q", K_Q, 4'b1110);
        expect_v("shr2.sout_r", K_SR, 4'd0);
        tick();

        // en low holds
        en = 1'b0; mode = 3'b010; sin_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_v("hold.q", K_Q, 4'b1110);
            tick();
        end
        en = 1'b1;
        expect_v("shl.q", K_Q, 4'b1101);
        tick();

        // load then ROL burst of 3, mode toggled mid-burst
        mode = 3'b011; pdata = 4'b0110;
        expect_v("load.q", K_Q, 4'b0110);
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b101; count = 3'd3;
        expect_st("rol.start", 4'b0110, 1'b1, 1'b0);
        tick();
        start = 1'b0; mode = 3'b000;
        expect_st("rol.b1", 4'b1100, 1'b1, 1'b0);
        tick();
        mode = 3'b111;
        expect_st("rol.b2", 4'b1001, 1'b1, 1'b0);
        tick();
        mode = 3'b011;
        expect_st("rol.b3", 4'b0011, 1'b0, 1'b1);
        tick();
        expect_st("rol.post", 4'b0011, 1'b0, 1'b0);
        tick();

        // ASR, CLR, zero-count start
        en = 1'b1; mode = 3'b011; pdata = 4'b1000;
        expect_v("load2.q", K_Q, 4'b1000);
        tick();
        mode = 3'b110;
        expect_v("asr.q", K_Q, 4'b1100);
        tick();
        mode = 3'b111;
        expect_v("clr.q", K_Q, 4'b0000);
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b001; count = 3'd0;
        expect_st("cnt0", 4'b0000, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        expect_st("cnt0.post", 4'b0000, 1'b0, 1'b0);
        tick();

        // SHR burst of 4 with live sin_r, restart ignored while busy
        start = 1'b1; mode = 3'b001; count = 3'd4;
        expect_st("shrb.start", 4'b0000, 1'b1, 1'b0);
        tick();
        sin_r = 1'b1;
        expect_st("shrb.b1", 4'b1000, 1'b1, 1'b0);
        tick();
        start = 1'b0; sin_r = 1'b0;
        expect_st("shrb.b2", 4'b0100, 1'b1, 1'b0);
        tick();
        sin_r = 1'b1;
        expect_st("shrb.b3", 4'b1010, 1'b1, 1'b0);
        tick();
        expect_st("shrb.b4", 4'b1101, 1'b0, 1'b1);
        tick();
        start = 1'b1;
        expect_st("shrb.done_start", 4'b1101, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        expect_st("shrb.idle", 4'b1101, 1'b0, 1'b0);
        tick();

        // ROR burst aborted by reset
        start = 1'b1; mode = 3'b100; count = 3'd5;
        expect_st("ror.start", 4'b1101, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        expect_st("ror.b1", 4'b1110, 1'b1, 1'b0);
        tick();
        expect_st("ror.b2", 4'b0111, 1'b1, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        expect_st("abort", 4'b1010, 1'b0, 1'b0);
        drain();
        #2;
        reset = 1'b0;
        expect_st("abort.post1", 4'b1010, 1'b0, 1'b0);
        tick();
        expect_st("abort.post2", 4'b1010, 1'b0, 1'b0);
        tick();
        en = 1'b1; mode = 3'b010; sin_l = 1'b0;
        expect_st("after.shl", 4'b0100, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
